ch_acc_relu: RTL and testbench
==============================

CH_ACC_RELU -- requirements
Module: ch_acc_relu

Interface
REQ-001 Parameter WIDTH, default 16: signed pixel and bias width, and output width.
REQ-002 Parameter ACC_WIDTH, default 32: partial-sum width.
REQ-003 Parameter MAX_nPixel, default 64: maximum pixels per channel pass.
REQ-004 Parameter MAX_nChannel, default 64: maximum input channels accumulated.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle job start; latches config_bits and bias.
REQ-008 config_bits  in  clog2(MAX_nChannel)+clog2(MAX_nPixel)  upper field nChannel-1, lower field nPixel-1.
REQ-009 bias  in  WIDTH  signed bias added at the final pass.
REQ-010 data_in  in  WIDTH  signed partial-sum pixel from the convolution array.
REQ-011 data_in_en  in  1  data_in valid; no backpressure.
REQ-012 data_out  out  WIDTH  activated pixel to the pooling stage; 0 when data_out_en is low.
REQ-013 data_out_en  out  1  data_out valid.
REQ-014 busy  out  1  high from the cycle after start until done.
REQ-015 done  out  1  one-cycle pulse after the last output.

Function
REQ-016 Config SHALL be latched on start in IDLE; start SHALL be ignored outside IDLE.
REQ-017 Job: nChannel passes, each of nPixel valid inputs in raster order; pixel index = count of data_in_en beats within the pass.
REQ-018 FSM states: IDLE, ACC (passes 0..nChannel-2), OUT (pass nChannel-1), DRAIN (2 cycles), then back to IDLE.
REQ-019 Transitions: IDLE->ACC on start if nChannel>1, else IDLE->OUT; ACC->OUT after the last beat of pass nChannel-2; OUT->DRAIN after the last beat of the final pass; DRAIN->IDLE after 2 cycles, asserting done in the last DRAIN cycle.
REQ-020 Counters: pix_cnt wraps nPixel-1->0 on a beat; ch_cnt increments on each pix_cnt wrap.
REQ-021 Per beat: psum[pix] = (ch_cnt==0 ? 0 : psum[pix]) + sign-extended data_in, as ACC_WIDTH two's-complement with wrap; stored psum contents SHALL NOT be read during pass 0.
REQ-022 Pipeline: stage 1 registers input and index and issues the synchronous RAM read; stage 2 adds, writes back, and produces output.
REQ-023 Read-after-write hazard (nPixel=1, or a stage-2 write address equal to the stage-1 read address): the stage-2 sum SHALL be forwarded in place of the RAM read data.
REQ-024 OUT pass: y = psum_new + sign-extended bias; y<0 -> 0; y>2^(WIDTH-1)-1 -> 2^(WIDTH-1)-1; otherwise y[WIDTH-1:0].
REQ-025 data_out_en SHALL assert exactly 2 cycles after each OUT-pass beat, once per beat, and never in ACC.
REQ-026 Gaps in data_in_en SHALL stall counters and pipeline-advance logic only; data already in flight SHALL still complete.
REQ-027 Beats arriving in IDLE or DRAIN SHALL be ignored.

Reset
REQ-028 On rst low: state IDLE, counters 0, pipeline valids 0, data_out 0, data_out_en 0, busy 0, done 0.
REQ-029 Reset mid-job SHALL abort the job with no further output; RAM contents are not cleared (pass 0 ignores them).

Structure
REQ-030 A shared package SHALL hold the state enum and the config-field width/offset constants shared with the conv array and the pooling stage.
REQ-031 Sub-module psum_ram: simple dual-port RAM, MAX_nPixel x ACC_WIDTH, 1-cycle synchronous read, write-first not relied upon.

Verification
REQ-032 nPixel=4, nChannel=1, bias=0, inputs {-3,5,0,7} -> outputs {0,5,0,7}, each 2 cycles after its input; done once.
REQ-033 nPixel=4, nChannel=3, bias=2, every input 10 -> no output during passes 0-1; then 4 outputs of 32.
REQ-034 nPixel=1, nChannel=4, back-to-back inputs {1,2,3,4}, bias=-1 -> single output 9 (forwarding path).
REQ-035 nPixel=2, nChannel=2, inputs 30000 each, bias=30000 -> outputs 32767 (saturation); inputs -30000 -> outputs 0.
REQ-036 Random gaps on data_in_en with nPixel=8, nChannel=5 -> outputs match the golden model; start pulsed while busy has no effect.
REQ-037 rst low mid-pass 1, then a new job nPixel=2, nChannel=1, inputs {4,6} -> outputs {4,6} with no stale residue.

Source files
------------

// File: rtl/ch_acc_relu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ch_acc_relu_pkg
// Description : Shared definitions for the channel accumulator / ReLU stage.
//               Holds the controller state encoding and the config_bits field
//               layout, which is also used by the conv array and the pooling
//               stage so all three agree on the packing.
//               config_bits = { nChannel-1 , nPixel-1 }
// Revision    : 1.0 - initial release
// ============================================================================
package ch_acc_relu_pkg;

    // Controller states
    localparam int         c_state_w  = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_acc   = 2'd1;  // passes 0 .. nChannel-2
    localparam logic [1:0] c_st_out   = 2'd2;  // final pass, outputs produced
    localparam logic [1:0] c_st_drain = 2'd3;  // pipeline flush, 2 cycles

    // Lower config field (nPixel-1) starts at bit 0
    localparam int c_cfg_pix_lsb = 0;

    // Width of a count field able to hold max_count-1 (at least one bit)
    function automatic int f_field_w(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    // Total config_bits width
    function automatic int f_cfg_w(input int max_nch, input int max_npix);
        return f_field_w(max_nch) + f_field_w(max_npix);
    endfunction

    // Upper config field (nChannel-1) sits directly above the pixel field
    function automatic int f_cfg_ch_lsb(input int max_npix);
        return c_cfg_pix_lsb + f_field_w(max_npix);
    endfunction

endpackage : ch_acc_relu_pkg
`default_nettype wire

// File: rtl/ch_acc_relu_psum_ram.sv
`default_nettype none
// ============================================================================
// Module      : ch_acc_relu_psum_ram
// Description : Simple dual-port partial-sum store, one write port and one
//               read port, 1-cycle synchronous read. A read and a write to the
//               same address in one cycle return the old contents; callers
//               must forward around that case.
// Ports       : clk        - clock
//               i_wr_en    - write enable
//               i_wr_addr  - write address
//               i_wr_data  - write data
//               i_rd_en    - read enable (read data holds when low)
//               i_rd_addr  - read address
//               o_rd_data  - read data, valid the cycle after i_rd_en
// Revision    : 1.0 - initial release
// ============================================================================
module ch_acc_relu_psum_ram
    import ch_acc_relu_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = f_field_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : ch_acc_relu_psum_ram
`default_nettype wire

// File: rtl/ch_acc_relu.sv
`default_nettype none
// ============================================================================
// Module      : ch_acc_relu
// Description : Accumulates per-pixel partial sums over nChannel input passes,
//               then on the final pass adds a bias, applies ReLU with
//               saturation to WIDTH bits and streams the result onward.
//               Two-stage pipeline: stage 1 registers the beat and issues the
//               psum read, stage 2 adds, writes back and drives the output.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous reset, active low
//               start       - one-cycle job start (accepted in IDLE only)
//               config_bits - {nChannel-1, nPixel-1}, latched on start
//               bias        - signed bias, latched on start
//               data_in     - signed partial-sum pixel
//               data_in_en  - data_in valid
//               data_out    - activated pixel, 0 when data_out_en is low
//               data_out_en - data_out valid
//               busy        - job in progress
//               done        - one-cycle pulse after the last output
// Revision    : 1.0 - initial release
// ============================================================================
module ch_acc_relu
    import ch_acc_relu_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int MAX_NPIXEL   = 64,
    parameter int MAX_NCHANNEL = 64
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [f_cfg_w(MAX_NCHANNEL, MAX_NPIXEL)-1:0]    config_bits,
    input  logic signed [WIDTH-1:0]                         bias,
    input  logic signed [WIDTH-1:0]                         data_in,
    input  logic                                            data_in_en,
    output logic signed [WIDTH-1:0]                         data_out,
    output logic                                            data_out_en,
    output logic                                            busy,
    output logic                                            done
);

    localparam int c_pw     = f_field_w(MAX_NPIXEL);
    localparam int c_cw     = f_field_w(MAX_NCHANNEL);
    localparam int c_ch_lsb = f_cfg_ch_lsb(MAX_NPIXEL);

    // Largest positive WIDTH-bit value, widened to the bias-sum width
    localparam logic signed [ACC_WIDTH:0] c_out_max =
        {{(ACC_WIDTH-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};

    // ---------------------------------------------------------------- control
    logic [c_state_w-1:0]    r_state;
    logic                    r_drain_cnt;
    logic                    r_done;
    logic [c_pw-1:0]         r_npix_m1;
    logic [c_cw-1:0]         r_nch_m1;
    logic signed [WIDTH-1:0] r_bias;
    logic [c_pw-1:0]         r_pix_cnt;
    logic [c_cw-1:0]         r_ch_cnt;

    logic                    w_beat;
    logic                    w_pix_wrap;
    logic [c_cw-1:0]         w_last_acc_ch;

    assign w_beat        = data_in_en && ((r_state == c_st_acc) || (r_state == c_st_out));
    assign w_pix_wrap    = (r_pix_cnt == r_npix_m1);
    assign w_last_acc_ch = r_nch_m1 - c_cw'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_drain_cnt <= 1'b0;
            r_done      <= 1'b0;
            r_npix_m1   <= '0;
            r_nch_m1    <= '0;
            r_bias      <= '0;
            r_pix_cnt   <= '0;
            r_ch_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_npix_m1 <= config_bits[c_cfg_pix_lsb +: c_pw];
                        r_nch_m1  <= config_bits[c_ch_lsb +: c_cw];
                        r_bias    <= bias;
                        r_pix_cnt <= '0;
                        r_ch_cnt  <= '0;
                        r_state   <= (config_bits[c_ch_lsb +: c_cw] != '0) ? c_st_acc : c_st_out;
                    end
                end
                c_st_acc, c_st_out: begin
                    if (data_in_en) begin
                        if (w_pix_wrap) begin
                            r_pix_cnt <= '0;
                            r_ch_cnt  <= r_ch_cnt + c_cw'(1);
                            if (r_state == c_st_out) begin
                                r_state     <= c_st_drain;
                                r_drain_cnt <= 1'b0;
                            end else if (r_ch_cnt == w_last_acc_ch) begin
                                r_state <= c_st_out;
                            end
                        end else begin
                            r_pix_cnt <= r_pix_cnt + c_pw'(1);
                        end
                    end
                end
                c_st_drain: begin
                    if (r_drain_cnt) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = (r_state != c_st_idle);
    assign done = r_done;

    // ---------------------------------------------------------------- stage 1
    logic                        r_s1_valid;
    logic [c_pw-1:0]             r_s1_pix;
    logic signed [WIDTH-1:0]     r_s1_data;
    logic                        r_s1_first;
    logic                        r_s1_out;
    logic                        r_fwd_hit;
    logic signed [ACC_WIDTH-1:0] r_fwd_data;

    logic [ACC_WIDTH-1:0]        w_ram_rd;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_data  <= '0;
            r_s1_first <= 1'b0;
            r_s1_out   <= 1'b0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_s1_valid <= w_beat;
            if (w_beat) begin
                r_s1_pix   <= r_pix_cnt;
                r_s1_data  <= data_in;
                r_s1_first <= (r_ch_cnt == '0);
                r_s1_out   <= (r_state == c_st_out);
            end
            // The RAM returns pre-write data when this read collides with the
            // stage-2 write in the same cycle; remember the sum being written.
            r_fwd_hit  <= w_beat && r_s1_valid && (r_s1_pix == r_pix_cnt);
            r_fwd_data <= w_sum;
        end
    end

    // Pass 0 never reads: RAM contents may be stale from an earlier job.
    ch_acc_relu_psum_ram #(
        .DEPTH  (MAX_NPIXEL),
        .DATA_W (ACC_WIDTH),
        .ADDR_W (c_pw)
    ) u_psum_ram (
        .clk       (clk),
        .i_wr_en   (r_s1_valid),
        .i_wr_addr (r_s1_pix),
        .i_wr_data (w_sum),
        .i_rd_en   (w_beat && (r_ch_cnt != '0)),
        .i_rd_addr (r_pix_cnt),
        .o_rd_data (w_ram_rd)
    );

    // ---------------------------------------------------------------- stage 2
    logic signed [ACC_WIDTH:0]   w_y;
    logic signed [WIDTH-1:0]     w_relu;

    assign w_base = r_s1_first ? '0 : (r_fwd_hit ? r_fwd_data : $signed(w_ram_rd));
    assign w_sum  = w_base + ACC_WIDTH'(r_s1_data);
    // One extra bit so sum + bias cannot wrap before the clamp
    assign w_y    = (ACC_WIDTH+1)'(w_sum) + (ACC_WIDTH+1)'(r_bias);

    always_comb begin
        w_relu = w_y[WIDTH-1:0];
        if (w_y[ACC_WIDTH]) begin
            w_relu = '0;
        end else if (w_y > c_out_max) begin
            w_relu = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_en <= 1'b0;
            data_out    <= '0;
        end else begin
            data_out_en <= r_s1_valid && r_s1_out;
            data_out    <= (r_s1_valid && r_s1_out) ? w_relu : '0;
        end
    end

endmodule : ch_acc_relu
`default_nettype wire

// File: tb/tb_ch_acc_relu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ch_acc_relu
// Description : Self-checking bench for ch_acc_relu. A per-pixel sum model
//               builds the expected output stream; a single compare process
//               checks data_out/data_out_en on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ch_acc_relu;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [11:0]        config_bits = '0;
    logic signed [15:0] bias = '0;
    logic signed [15:0] data_in = '0;
    logic               data_in_en = 1'b0;
    logic signed [15:0] data_out;
    logic               data_out_en;
    logic               busy;
    logic               done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    typedef struct {
        int cyc;
        int val;
    } exp_t;
    exp_t exp_q[$];

    ch_acc_relu #(
        .WIDTH        (16),
        .ACC_WIDTH    (32),
        .MAX_NPIXEL   (64),
        .MAX_NCHANNEL (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .config_bits (config_bits),
        .bias        (bias),
        .data_in     (data_in),
        .data_in_en  (data_in_en),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: either the scheduled output appears, or the output is idle.
    always @(negedge clk) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            if (data_out_en !== 1'b1 || data_out !== 16'(exp_q[0].val)) begin
                errors++;
                $display("FAIL out_value cyc=%0d got en=%0b data=%0d expected en=1 data=%0d",
                         cyc, data_out_en, data_out, exp_q[0].val);
            end
            void'(exp_q.pop_front());
        end else if (data_out_en !== 1'b0 || data_out !== 16'sd0) begin
            errors++;
            $display("FAIL out_idle cyc=%0d got en=%0b data=%0d expected en=0 data=0",
                     cyc, data_out_en, data_out);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Output for pixel p = clamp(sum over channels of din + bias, 0, 32767)
    function automatic void model(input int npix, input int nch, input int b,
                                  input int din[$], output int res[$]);
        longint acc;
        res = {};
        for (int p = 0; p < npix; p++) begin
            acc = b;
            for (int c = 0; c < nch; c++) acc += din[c*npix + p];
            if (acc < 0) acc = 0;
            else if (acc > 32767) acc = 32767;
            res.push_back(int'(acc));
        end
    endfunction

    task automatic run_job(input string tag, input int npix, input int nch, input int b,
                           input int din[$], input int lit[$], input int gap_pct,
                           input bit poke);
        int res[$];
        int idx;
        int last;
        int dc0;
        model(npix, nch, b, din, res);
        for (int p = 0; p < lit.size(); p++) chk({tag, "_model"}, res[p], lit[p]);
        @(posedge clk); #1;
        config_bits = {6'(nch-1), 6'(npix-1)};
        bias        = 16'(b);
        start       = 1'b1;
        dc0         = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        idx  = 0;
        last = cyc;
        while (idx < npix*nch) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                data_in_en = 1'b0;
                data_in    = 16'sh7fff;
                if (poke) begin
                    start       = 1'b1;
                    config_bits = 12'h000;
                    bias        = 16'sd1000;
                end
            end else begin
                data_in_en = 1'b1;
                data_in    = 16'(din[idx]);
                if (idx >= (nch-1)*npix) exp_q.push_back('{cyc + 2, res[idx % npix]});
                last = cyc;
                idx++;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        data_in_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, done_cnt - dc0, 1);
        chk({tag, "_done_cycle"}, done_cyc, last + 3);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int d[$];
        int l[$];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_out_en", data_out_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;

        // Single channel, ReLU clamps negatives
        d = {}; l = {};
        d.push_back(-3); d.push_back(5); d.push_back(0); d.push_back(7);
        l.push_back(0);  l.push_back(5); l.push_back(0); l.push_back(7);
        run_job("c1", 4, 1, 0, d, l, 0, 1'b0);

        // Three channels, constant input
        d = {}; l = {};
        for (int i = 0; i < 12; i++) d.push_back(10);
        for (int i = 0; i < 4; i++) l.push_back(32);
        run_job("c3", 4, 3, 2, d, l, 0, 1'b0);

        // One pixel, back-to-back: every read collides with the prior write
        d = {}; l = {};
        d.push_back(1); d.push_back(2); d.push_back(3); d.push_back(4);
        l.push_back(9);
        run_job("fwd", 1, 4, -1, d, l, 0, 1'b0);

        // Saturation high and clamp low
        d = {}; l = {};
        for (int i = 0; i < 4; i++) d.push_back(30000);
        l.push_back(32767); l.push_back(32767);
        run_job("sat_hi", 2, 2, 30000, d, l, 0, 1'b0);
        d = {}; l = {};
        for (int i = 0; i < 4; i++) d.push_back(-30000);
        l.push_back(0); l.push_back(0);
        run_job("sat_lo", 2, 2, 30000, d, l, 0, 1'b0);

        // Beats outside a job produce nothing
        for (int i = 0; i < 3; i++) begin
            data_in_en = 1'b1;
            data_in    = 16'sd55;
            @(posedge clk); #1;
        end
        data_in_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_beats_busy", busy, 0);

        // Random gaps, start pulsed while busy
        d = {}; l = {};
        for (int i = 0; i < 40; i++) d.push_back(int'($urandom_range(2000)) - 1000);
        run_job("gaps", 8, 5, 7, d, l, 30, 1'b1);

        // Reset in the middle of pass 1
        @(posedge clk); #1;
        config_bits = {6'd2, 6'd3};
        bias        = 16'sd0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_in_en = 1'b1;
            data_in    = 16'sd100;
            @(posedge clk); #1;
        end
        data_in_en = 1'b0;
        rst        = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_en", data_out_en, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        d = {}; l = {};
        d.push_back(4); d.push_back(6);
        l.push_back(4); l.push_back(6);
        run_job("after_rst", 2, 1, 0, d, l, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ch_acc_relu
`default_nettype wire
